// File: rtl/sa_ram_pkg.sv
// sa_ram_pkg: shared state type and word helpers for sa_ram_rws_param.
// Helpers take words zero-extended to SA_RAM_MAXW bits.
package sa_ram_pkg;

  localparam int SA_RAM_MAXW    = 512;
  localparam int SA_RAM_MAXNSEG = 512;

  typedef enum logic {
    S_INIT,
    S_RUN
  } sa_ram_state_e;

  function automatic logic [SA_RAM_MAXW-1:0] sa_ram_merge(
    input logic [SA_RAM_MAXW-1:0]    old_w,
    input logic [SA_RAM_MAXW-1:0]    new_w,
    input logic [SA_RAM_MAXNSEG-1:0] mask,
    input int                        seg
  );
    logic [SA_RAM_MAXW-1:0] res;
    res = old_w;
    for (int b = 0; b < SA_RAM_MAXW; b++) begin
      if (mask[b / seg]) res[b] = new_w[b];
    end
    return res;
  endfunction

  // Even parity: one bit per segment, equal to the XOR of its data bits.
  function automatic logic [SA_RAM_MAXNSEG-1:0] sa_ram_par(
    input logic [SA_RAM_MAXW-1:0] word,
    input int                     seg
  );
    logic [SA_RAM_MAXNSEG-1:0] p;
    p = '0;
    for (int b = 0; b < SA_RAM_MAXW; b++) begin
      p[b / seg] = p[b / seg] ^ word[b];
    end
    return p;
  endfunction

endpackage

// File: rtl/sa_ram_rws_init_ctrl.sv
// sa_ram_rws_init_ctrl: post-reset zero-fill sequencer for sa_ram_rws_param.
// Sweeps every address once, one word per cycle, then hands over to traffic.
module sa_ram_rws_init_ctrl
  import sa_ram_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int INIT_ZERO = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_init_busy,
  output logic [AW-1:0] o_init_wa,
  output logic          o_init_we
);

  sa_ram_state_e r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= (INIT_ZERO != 0) ? S_INIT : S_RUN;
      r_cnt   <= '0;
      r_busy  <= (INIT_ZERO != 0);
    end else begin
      unique case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= S_RUN;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_init_busy = r_busy;
  assign o_init_we   = r_busy;
  assign o_init_wa   = r_cnt;

endmodule

// File: rtl/sa_ram_rws_param.sv
// sa_ram_rws_param: parametrised 1R1W RAM model with masked writes and
// read-valid strobe. Define SA_RAM_PARITY_EN for per-segment parity.
module sa_ram_rws_param
  import sa_ram_pkg::*;
#(
  parameter int DW        = 272,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int SEG       = 8,
  parameter int OUT_REG   = 0,
  parameter int BYPASS    = 1,
  parameter int INIT_ZERO = 0,
  localparam int NSEG     = DW / SEG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra,
  input  logic            re,
  output logic [DW-1:0]   dout,
  output logic            dout_vld,
  input  logic [AW-1:0]   wa,
  input  logic            we,
  input  logic [NSEG-1:0] wmask,
  input  logic [DW-1:0]   di,
  output logic            init_busy,
  output logic            par_err,
  input  logic [31:0]     pwrbus_ram_pd
);

  logic            w_busy;
  logic            w_init_we;
  logic [AW-1:0]   w_init_wa;
  logic            w_we;
  logic [AW-1:0]   w_wa;
  logic [NSEG-1:0] w_wm;
  logic [DW-1:0]   w_di;
  logic            w_re;

  sa_ram_rws_init_ctrl #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .INIT_ZERO(INIT_ZERO)
  ) u_init (
    .clk        (clk),
    .rst        (rst),
    .o_init_busy(w_busy),
    .o_init_wa  (w_init_wa),
    .o_init_we  (w_init_we)
  );

  // The sweep owns the write port while it runs; user traffic is dropped.
  always_comb begin
    w_we = we;
    w_wa = wa;
    w_wm = wmask;
    w_di = di;
    if (w_init_we) begin
      w_we = 1'b1;
      w_wa = w_init_wa;
      w_wm = '1;
      w_di = '0;
    end
  end

  assign w_re      = re & ~w_busy;
  assign init_busy = w_busy;

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int s = 0; s < NSEG; s++) begin
        if (w_wm[s]) r_mem[w_wa][s*SEG +: SEG] <= w_di[s*SEG +: SEG];
      end
    end
  end

  logic                   w_coll;
  logic [DW-1:0]          w_old;
  logic [DW-1:0]          w_rdata;
  logic [SA_RAM_MAXW-1:0] w_mrg_x;
  logic                   w_perr_now;
  logic                   w_unused_bits;

  assign w_old   = r_mem[ra];
  assign w_coll  = we & ~w_busy & (ra == wa);
  assign w_mrg_x = sa_ram_merge(SA_RAM_MAXW'(w_old),
                                SA_RAM_MAXW'(di),
                                SA_RAM_MAXNSEG'(wmask),
                                SEG);
  assign w_rdata = ((BYPASS != 0) && w_coll) ? w_mrg_x[DW-1:0] : w_old;

  assign w_unused_bits = ^{pwrbus_ram_pd, w_mrg_x[SA_RAM_MAXW-1:DW]};

`ifdef SA_RAM_PARITY_EN
  logic [NSEG-1:0]           r_par [DEPTH];
  logic [SA_RAM_MAXNSEG-1:0] w_pw_x;
  logic [SA_RAM_MAXNSEG-1:0] w_pr_x;
  logic [NSEG-1:0]           w_rpar;
  logic                      w_unused_par;

  assign w_pw_x = sa_ram_par(SA_RAM_MAXW'(w_di), SEG);

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int s = 0; s < NSEG; s++) begin
        if (w_wm[s]) r_par[w_wa][s] <= w_pw_x[s];
      end
    end
  end

  // Bypassed segments carry parity generated from the incoming data.
  assign w_rpar = ((BYPASS != 0) && w_coll)
                ? ((r_par[ra] & ~wmask) | (w_pw_x[NSEG-1:0] & wmask))
                : r_par[ra];
  assign w_pr_x     = sa_ram_par(SA_RAM_MAXW'(w_rdata), SEG);
  assign w_perr_now = |(w_pr_x[NSEG-1:0] ^ w_rpar);

  assign w_unused_par = ^{w_pw_x[SA_RAM_MAXNSEG-1:NSEG],
                          w_pr_x[SA_RAM_MAXNSEG-1:NSEG]};
`else
  assign w_perr_now = 1'b0;
`endif

  logic [DW-1:0] r_rd;
  logic          r_rvld;
  logic          r_rperr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_rvld  <= 1'b0;
      r_rperr <= 1'b0;
    end else begin
      r_rvld  <= w_re;
      r_rperr <= w_re & w_perr_now;
      if (w_re) r_rd <= w_rdata;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] r_dout;
      logic          r_vld;
      logic          r_perr;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout <= '0;
          r_vld  <= 1'b0;
          r_perr <= 1'b0;
        end else begin
          r_vld  <= r_rvld;
          r_perr <= r_rperr;
          if (r_rvld) r_dout <= r_rd;
        end
      end

      assign dout     = r_dout;
      assign dout_vld = r_vld;
      assign par_err  = r_perr;
    end else begin : g_noreg
      assign dout     = r_rd;
      assign dout_vld = r_rvld;
      assign par_err  = r_rperr;
    end
  endgenerate

endmodule

// File: tb/tb_sa_ram_rws_param.sv
// tb_sa_ram_rws_param: three configurations of sa_ram_rws_param on shared
// stimulus, read results checked against a per-instance expected-data queue.
module tb_sa_ram_rws_param;

  typedef struct {
    logic [271:0] d;
    int           due;
    bit           chk;
    bit           perr;
  } ent_t;

  logic         clk;
  logic         rst;
  logic [3:0]   ra;
  logic         re;
  logic [3:0]   wa;
  logic         we;
  logic [33:0]  wmask;
  logic [271:0] di;
  logic [31:0]  pwr;

  logic [271:0] dout_a [3];
  logic         vld_a  [3];
  logic         busy_a [3];
  logic         perr_a [3];

  ent_t         q [3][$];
  logic [271:0] m  [16];
  logic [271:0] m2 [16];
  bit           kn [16];
  bit           bad [16];
  bit           b2;
  bit           mon_on;
  int           cyc;
  int           n_chk;
  int           n_fail;
  int           pulses1;

  sa_ram_rws_param #(.OUT_REG(0), .BYPASS(1), .INIT_ZERO(0)) u0 (
    .clk(clk), .rst(rst), .ra(ra), .re(re),
    .dout(dout_a[0]), .dout_vld(vld_a[0]),
    .wa(wa), .we(we), .wmask(wmask), .di(di),
    .init_busy(busy_a[0]), .par_err(perr_a[0]),
    .pwrbus_ram_pd(pwr)
  );

  sa_ram_rws_param #(.OUT_REG(1), .BYPASS(0), .INIT_ZERO(0)) u1 (
    .clk(clk), .rst(rst), .ra(ra), .re(re),
    .dout(dout_a[1]), .dout_vld(vld_a[1]),
    .wa(wa), .we(we), .wmask(wmask), .di(di),
    .init_busy(busy_a[1]), .par_err(perr_a[1]),
    .pwrbus_ram_pd(pwr)
  );

  sa_ram_rws_param #(.OUT_REG(0), .BYPASS(1), .INIT_ZERO(1)) u2 (
    .clk(clk), .rst(rst), .ra(ra), .re(re),
    .dout(dout_a[2]), .dout_vld(vld_a[2]),
    .wa(wa), .we(we), .wmask(wmask), .di(di),
    .init_busy(busy_a[2]), .par_err(perr_a[2]),
    .pwrbus_ram_pd(pwr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < 3; k++) begin
        if (vld_a[k] === 1'b1) begin
          n_chk++;
          if (q[k].size() == 0) begin
            n_fail++;
            $display("FAIL u%0d_spurious_vld cyc=%0d dout=%h want no pulse",
                     k, cyc, dout_a[k]);
          end else begin
            ent_t e;
            bit   bd;
            e  = q[k].pop_front();
            bd = e.chk && (dout_a[k] !== e.d || perr_a[k] !== e.perr);
            if (bd || cyc != e.due) begin
              n_fail++;
              $display("FAIL u%0d_read got d=%h cyc=%0d perr=%b want d=%h cyc=%0d perr=%b",
                       k, dout_a[k], cyc, perr_a[k], e.d, e.due, e.perr);
            end
            if (k == 1) pulses1++;
          end
        end else begin
          n_chk++;
          if (vld_a[k] !== 1'b0 || perr_a[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL u%0d_idle got vld=%b perr=%b want 0 0",
                     k, vld_a[k], perr_a[k]);
          end
        end
      end
    end
  end

  function automatic logic [271:0] mrg(input logic [271:0] o,
                                       input logic [271:0] n,
                                       input logic [33:0]  mk);
    logic [271:0] r;
    r = o;
    for (int s = 0; s < 34; s++) begin
      if (mk[s]) r[s*8 +: 8] = n[s*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [271:0] rnd();
    logic [287:0] t;
    for (int j = 0; j < 9; j++) t[j*32 +: 32] = $urandom;
    return t[271:0];
  endfunction

  task automatic drv(input bit re_, input int ra_, input bit we_,
                     input int wa_, input logic [33:0] wm_,
                     input logic [271:0] di_);
    ent_t e;
    bit   cl;
    @(posedge clk);
    #1;
    re    = re_;
    ra    = ra_[3:0];
    we    = we_;
    wa    = wa_[3:0];
    wmask = wm_;
    di    = di_;
    cl    = we_ && (wa_ == ra_);
    if (re_) begin
      e.chk  = kn[ra_];
      e.perr = bad[ra_];
      e.d    = cl ? mrg(m[ra_], di_, wm_) : m[ra_];
      e.due  = cyc + 1;
      q[0].push_back(e);
      e.d    = m[ra_];
      e.due  = cyc + 2;
      q[1].push_back(e);
      if (!b2) begin
        e.chk  = 1'b1;
        e.perr = 1'b0;
        e.d    = cl ? mrg(m2[ra_], di_, wm_) : m2[ra_];
        e.due  = cyc + 1;
        q[2].push_back(e);
      end
    end
    if (we_) begin
      kn[wa_] = kn[wa_] || (wm_ == '1);
      if (wm_ == '1) bad[wa_] = 1'b0;
      m[wa_] = mrg(m[wa_], di_, wm_);
      if (!b2) m2[wa_] = mrg(m2[wa_], di_, wm_);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 0, 1'b0, 0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (dout_a[k] !== '0 || vld_a[k] !== 1'b0 || perr_a[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out u%0d got dout=%h vld=%b perr=%b want 0 0 0",
                 k, dout_a[k], vld_a[k], perr_a[k]);
      end
    end
    n_chk++;
    if (busy_a[0] !== 1'b0 || busy_a[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy got u0=%b u2=%b want 0 1", busy_a[0], busy_a[2]);
    end
    mon_on = 1'b1;
  endtask

  task automatic test_init();
    int   n;
    ent_t e;
    b2 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_a[2] === 1'b1) n++;
      if (i == 4) begin
        re     = 1'b1;
        ra     = 4'd3;
        e.d    = '0;
        e.chk  = 1'b0;
        e.perr = 1'b0;
        e.due  = cyc + 1;
        q[0].push_back(e);
        e.due  = cyc + 2;
        q[1].push_back(e);
      end
      if (i == 5) re = 1'b0;
      if (i == 9) begin
        we    = 1'b1;
        wa    = 4'd0;
        wmask = '1;
        di    = '1;
        m[0]  = '1;
        kn[0] = 1'b1;
      end
      if (i == 10) we = 1'b0;
      if (busy_a[2] !== 1'b1) break;
    end
    n_chk++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL init_busy_len got %0d cycles want 16", n);
    end
    n_chk++;
    if (busy_a[0] !== 1'b0 || busy_a[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL init_busy_off got u0=%b u1=%b want 0 0", busy_a[0], busy_a[1]);
    end
    b2 = 1'b0;
    for (int a = 0; a < 16; a++) m2[a] = '0;
    for (int a = 0; a < 16; a++) drv(1'b1, a, 1'b0, 0, '0, '0);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (q[k].size() != 0) begin
        n_fail++;
        $display("FAIL init_drain u%0d pending=%0d want 0", k, q[k].size());
      end
    end
  endtask

  task automatic test_basic();
    logic [271:0] a5;
    a5 = {34{8'hA5}};
    drv(1'b0, 0, 1'b1, 3, '1, a5);
    drv(1'b1, 3, 1'b0, 0, '0, '0);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (q[k].size() != 0) begin
        n_fail++;
        $display("FAIL basic_drain u%0d pending=%0d want 0", k, q[k].size());
      end
    end
  endtask

  task automatic test_mask();
    drv(1'b0, 0, 1'b1, 5, '1, '1);
    drv(1'b0, 0, 1'b1, 5, 34'h1, '0);
    drv(1'b0, 0, 1'b1, 5, '0, '0);
    drv(1'b1, 5, 1'b0, 0, '0, '0);
    drv(1'b0, 0, 1'b1, 6, '1, rnd());
    drv(1'b0, 0, 1'b1, 6, 34'h2_AAAA_5555, rnd());
    drv(1'b1, 6, 1'b0, 0, '0, '0);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (q[k].size() != 0) begin
        n_fail++;
        $display("FAIL mask_drain u%0d pending=%0d want 0", k, q[k].size());
      end
    end
  endtask

  task automatic test_collision();
    logic [271:0] x;
    logic [271:0] y;
    x = {17{16'h1234}};
    y = {17{16'hBEEF}};
    drv(1'b0, 0, 1'b1, 2, '1, x);
    drv(1'b1, 2, 1'b1, 2, '1, y);
    drv(1'b1, 2, 1'b0, 0, '0, '0);
    drv(1'b1, 2, 1'b1, 2, 34'h0_0F0F_00FF, rnd());
    drv(1'b1, 2, 1'b0, 0, '0, '0);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (q[k].size() != 0) begin
        n_fail++;
        $display("FAIL coll_drain u%0d pending=%0d want 0", k, q[k].size());
      end
    end
  endtask

  task automatic test_stream();
    int p0;
    for (int a = 0; a < 16; a++) drv(1'b0, 0, 1'b1, a, '1, rnd());
    p0 = pulses1;
    for (int a = 0; a < 16; a++) begin
      drv(1'b1, a, 1'b1, (a + 1) % 16, 34'($urandom), rnd());
    end
    idle(5);
    n_chk++;
    if (pulses1 - p0 != 16) begin
      n_fail++;
      $display("FAIL stream_pulses got %0d want 16", pulses1 - p0);
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (q[k].size() != 0) begin
        n_fail++;
        $display("FAIL stream_drain u%0d pending=%0d want 0", k, q[k].size());
      end
    end
  endtask

  task automatic test_hold();
    logic [271:0] l0;
    logic [271:0] l2;
    l0 = m[7];
    l2 = m2[7];
    drv(1'b1, 7, 1'b0, 0, '0, '0);
    idle(2);
    drv(1'b0, 0, 1'b1, 7, '1, ~l0);
    idle(3);
    @(negedge clk);
    n_chk++;
    if (dout_a[0] !== l0 || dout_a[1] !== l0) begin
      n_fail++;
      $display("FAIL hold_dout got u0=%h u1=%h want %h", dout_a[0], dout_a[1], l0);
    end
    n_chk++;
    if (dout_a[2] !== l2) begin
      n_fail++;
      $display("FAIL hold_dout_u2 got %h want %h", dout_a[2], l2);
    end
    drv(1'b1, 7, 1'b0, 0, '0, '0);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (q[k].size() != 0) begin
        n_fail++;
        $display("FAIL hold_drain u%0d pending=%0d want 0", k, q[k].size());
      end
    end
  endtask

`ifdef SA_RAM_PARITY_EN
  task automatic test_parity();
    logic [271:0] d;
    d = rnd();
    drv(1'b0, 0, 1'b1, 9, '1, d);
    idle(2);
    @(negedge clk);
    u0.r_mem[9][5] = ~u0.r_mem[9][5];
    u1.r_mem[9][5] = ~u1.r_mem[9][5];
    m[9][5] = ~m[9][5];
    bad[9]  = 1'b1;
    drv(1'b1, 9, 1'b0, 0, '0, '0);
    drv(1'b1, 3, 1'b0, 0, '0, '0);
    drv(1'b0, 0, 1'b1, 9, '1, d);
    drv(1'b1, 9, 1'b0, 0, '0, '0);
    idle(4);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (q[k].size() != 0) begin
        n_fail++;
        $display("FAIL par_drain u%0d pending=%0d want 0", k, q[k].size());
      end
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d want finish before timeout", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    re      = 1'b0;
    we      = 1'b0;
    ra      = '0;
    wa      = '0;
    wmask   = '0;
    di      = '0;
    pwr     = '0;
    b2      = 1'b1;
    mon_on  = 1'b0;
    cyc     = 0;
    n_chk   = 0;
    n_fail  = 0;
    pulses1 = 0;
    for (int a = 0; a < 16; a++) begin
      m[a]   = '0;
      m2[a]  = '0;
      kn[a]  = 1'b0;
      bad[a] = 1'b0;
    end
    test_reset();
    test_init();
    test_basic();
    test_mask();
    test_collision();
    test_stream();
    test_hold();
`ifdef SA_RAM_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
